// File: rtl/jtkcpu_pshpul_pkg.sv
// Shared definitions for the push/pull byte sequencer: state encoding,
// register-byte select codes, postbyte bit positions and default masks.
package jtkcpu_pshpul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH,
      ST_PULL,
      ST_RTI_CHK,
      ST_DONE
   } state_t;

   // reg_sel byte codes
   localparam logic [3:0] SEL_CC  = 4'd0;
   localparam logic [3:0] SEL_A   = 4'd1;
   localparam logic [3:0] SEL_B   = 4'd2;
   localparam logic [3:0] SEL_DP  = 4'd3;
   localparam logic [3:0] SEL_XH  = 4'd4;
   localparam logic [3:0] SEL_XL  = 4'd5;
   localparam logic [3:0] SEL_YH  = 4'd6;
   localparam logic [3:0] SEL_YL  = 4'd7;
   localparam logic [3:0] SEL_SPH = 4'd8;
   localparam logic [3:0] SEL_SPL = 4'd9;
   localparam logic [3:0] SEL_PCH = 4'd10;
   localparam logic [3:0] SEL_PCL = 4'd11;

   // postbyte bit positions; bits at or above BIT_X name 16-bit registers
   localparam int BIT_CC = 0;
   localparam int BIT_A  = 1;
   localparam int BIT_B  = 2;
   localparam int BIT_DP = 3;
   localparam int BIT_X  = 4;
   localparam int BIT_Y  = 5;
   localparam int BIT_S  = 6;
   localparam int BIT_PC = 7;

   localparam logic [7:0] PSHALL_MASK_DEF = 8'hFF;
   localparam logic [7:0] FIRQ_MASK_DEF   = 8'h81;
   localparam logic [7:0] RTI_CC_MASK     = 8'h01;
   localparam logic [7:0] RTI_PC_MASK     = 8'h80;
   localparam logic [3:0] CNT_MAX         = 4'd12;

   // Effective mask selection: pshall beats the FIRQ pair, which beats postbyte
   function automatic logic [7:0] eff_mask(
      input logic       pshall,
      input logic       pshpc,
      input logic       pshcc,
      input logic [7:0] postbyte,
      input logic [7:0] all_mask,
      input logic [7:0] firq_mask
   );
      if (pshall)
         return all_mask;
      else if (pshpc && pshcc)
         return firq_mask;
      else
         return postbyte;
   endfunction

endpackage

// File: rtl/jtkcpu_pshpul_if.sv
// Handshake and register-file/bus signals between the microcode sequencer
// side (master) and the push/pull sequencer (slave).
interface jtkcpu_pshpul_if;
   logic       cen;
   logic       psh_go;
   logic       pul_go;
   logic       pshall;
   logic       pshpc;
   logic       pshcc;
   logic       rti_cc;
   logic       cc_e;
   logic [7:0] postbyte;
   logic       mem_busy;
   logic       busy;
   logic [3:0] reg_sel;
   logic       we;
   logic       sp_dec;
   logic       sp_inc;
   logic       ld_en;
   logic       done;
   logic [3:0] xfer_cnt;

   modport slave (
      input  cen, psh_go, pul_go, pshall, pshpc, pshcc, rti_cc, cc_e,
             postbyte, mem_busy,
      output busy, reg_sel, we, sp_dec, sp_inc, ld_en, done, xfer_cnt
   );

   modport master (
      output cen, psh_go, pul_go, pshall, pshpc, pshcc, rti_cc, cc_e,
             postbyte, mem_busy,
      input  busy, reg_sel, we, sp_dec, sp_inc, ld_en, done, xfer_cnt
   );
endinterface

// File: rtl/jtkcpu_pshpul_pri.sv
// Priority encoder: picks the next register byte from the pending mask.
// Push walks from the highest set bit (low byte of a 16-bit register first),
// pull walks from the lowest set bit (high byte first). The mask bit is only
// released on the second byte of a 16-bit register.
module jtkcpu_pshpul_pri
   import jtkcpu_pshpul_pkg::*;
(
   input  logic [7:0] mask,
   input  logic       push,
   input  logic       half,
   output logic [3:0] sel,
   output logic [7:0] clr
);

   logic [2:0] idx;
   logic       hit;
   logic       wide;
   logic [3:0] base;

   // Locate the bit to service and translate it into a byte code
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      idx  = '0;
      hit  = 1'b0;
      wide = 1'b0;
      base = '0;
      sel  = '0;
      clr  = '0;
      if (push) begin
         for (int i = 0; i < 8; i++)
            if (mask[i]) begin
               idx = 3'(i);
               hit = 1'b1;
            end
      end else begin
         for (int i = 7; i >= 0; i--)
            if (mask[i]) begin
               idx = 3'(i);
               hit = 1'b1;
            end
      end
      if (hit) begin
         wide = (int'(idx) >= BIT_X);
         base = wide ? ({1'b0, idx[1:0], 1'b0} + SEL_XH) : {1'b0, idx};
         sel  = base + {3'b000, wide & (push ^ half)};
         if (!wide || half)
            clr = 8'(1) << idx;
      end
   end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Push/pull byte sequencer. Walks the latched register mask one byte per
// non-busy cen cycle, driving reg_sel and the stack/strobe controls, then
// pulses done for one cen cycle. RTI pulls CC first and decides the rest
// from its E flag.
// Optional: define JTKCPU_PSHPUL_CNT_EN to enable the xfer_cnt byte counter.
module jtkcpu_pshpul
   import jtkcpu_pshpul_pkg::*;
#(
   parameter logic [7:0] PSHALL_MASK = PSHALL_MASK_DEF,
   parameter logic [7:0] FIRQ_MASK   = FIRQ_MASK_DEF
)(
   input  logic             clk,
   input  logic             rst,
   jtkcpu_pshpul_if.slave   bus
);

   state_t     st, st_nx;
   logic [7:0] mask, mask_nx;
   logic       half, half_nx;
   logic       rti, rti_nx;
   logic [3:0] sel;
   logic [7:0] clr;
   logic [7:0] go_mask;
   logic       walking;
   logic       adv;

   jtkcpu_pshpul_pri u_pri (
      .mask (mask),
      .push (st == ST_PUSH),
      .half (half),
      .sel  (sel),
      .clr  (clr)
   );

   assign go_mask = eff_mask(bus.pshall, bus.pshpc, bus.pshcc, bus.postbyte,
                             PSHALL_MASK, FIRQ_MASK);
   assign walking = (st == ST_PUSH) || (st == ST_PULL);
   assign adv     = walking && bus.cen && !bus.mem_busy;

   // State register; rst is synchronous and active low
   always_ff @(posedge clk) begin
      if (!rst) begin
         st   <= ST_IDLE;
         mask <= '0;
         half <= 1'b0;
         rti  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         st   <= st_nx;
         mask <= mask_nx;
         half <= half_nx;
         rti  <= rti_nx;
      end
   end

   // Next-state logic: go acceptance, byte walk, RTI decision
   always_comb begin
      st_nx   = st;
      mask_nx = mask;
      half_nx = half;
      rti_nx  = rti;
      case (st)
         ST_IDLE: begin
            if (bus.cen && bus.psh_go) begin
               mask_nx = go_mask;
               half_nx = 1'b0;
               rti_nx  = 1'b0;
               st_nx   = (go_mask == '0) ? ST_DONE : ST_PUSH;
            end else if (bus.cen && bus.pul_go) begin
               half_nx = 1'b0;
               if (bus.rti_cc) begin
                  mask_nx = RTI_CC_MASK;
                  rti_nx  = 1'b1;
                  st_nx   = ST_PULL;
               end else begin
                  mask_nx = go_mask;
                  rti_nx  = 1'b0;
                  st_nx   = (go_mask == '0) ? ST_DONE : ST_PULL;
               end
            end
         end
         ST_PUSH, ST_PULL: begin
            if (adv) begin
               mask_nx = mask & ~clr;
               half_nx = (clr == '0);
               if (mask_nx == '0)
                  st_nx = (st == ST_PULL && rti) ? ST_RTI_CHK : ST_DONE;
            end
         end
         ST_RTI_CHK: begin
            if (bus.cen) begin
               mask_nx = bus.cc_e ? (PSHALL_MASK & ~RTI_CC_MASK) : RTI_PC_MASK;
               half_nx = 1'b0;
               rti_nx  = 1'b0;
               st_nx   = (mask_nx == '0) ? ST_DONE : ST_PULL;
            end
         end
         ST_DONE: begin
            if (bus.cen)
               st_nx = ST_IDLE;
         end
         default: st_nx = ST_IDLE;
      endcase
   end

   // Output decode; strobes that step SP or load data fire only on accepted bytes
   always_comb begin
      bus.busy    = walking || (st == ST_RTI_CHK);
      bus.reg_sel = walking ? sel : '0;
      bus.we      = (st == ST_PUSH);
      bus.sp_dec  = adv && (st == ST_PUSH);
      bus.sp_inc  = adv && (st == ST_PULL);
      bus.ld_en   = adv && (st == ST_PULL);
      bus.done    = (st == ST_DONE);
   end

`ifdef JTKCPU_PSHPUL_CNT_EN
   logic [3:0] cnt;
   logic       go_acc;

   assign go_acc = (st == ST_IDLE) && bus.cen && (bus.psh_go || bus.pul_go);

   // Accepted-byte counter: clears on go, saturates, holds until the next go
   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (go_acc)
         cnt <= '0;
      else if (adv && cnt != CNT_MAX)
         cnt <= cnt + 4'd1;
   end

   assign bus.xfer_cnt = cnt;
`else
   assign bus.xfer_cnt = '0;
`endif

endmodule
